// File: rtl/mux4_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mux4_rr_arbiter
// Brief    : Round-robin arbiter sharing one 4-bit data path among four
//            requesters, with valid/ready handoff and a bounded grant length.
// Revision : 1.0
// ============================================================================
module mux4_rr_arbiter #(
   parameter int MAX_HOLD = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] req,
   input  logic [3:0] a,
   input  logic [3:0] b,
   input  logic [3:0] c,
   input  logic [3:0] d,
   input  logic       out_ready,
   output logic [1:0] sel,
   output logic [3:0] gnt,
   output logic [3:0] y,
   output logic       y_valid,
   output logic [3:0] ack
);

   localparam logic [3:0] HOLD_LIMIT = 4'(MAX_HOLD);

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } state_t;

   state_t     state, state_nxt;
   logic [1:0] sel_nxt;
   logic [3:0] gnt_nxt;
   logic [1:0] ptr, ptr_nxt;
   logic [3:0] hold_cnt, hold_cnt_nxt;
   logic       accept;
   logic       release_now;
   logic [1:0] next_ptr;

   // First requester at or after position p, wrapping modulo 4.
   // Scanning from the farthest offset down lets the nearest one win.
   function automatic logic [1:0] winner(input logic [3:0] r, input logic [1:0] p);
      logic [1:0] w;
      logic [1:0] idx;
      w = p;
      for (int i = 3; i >= 0; i--) begin
         idx = p + 2'(i);
         if (r[idx]) w = idx;
      end
      return w;
   endfunction

   function automatic logic [3:0] onehot(input logic [1:0] s);
      return 4'b0001 << s;
   endfunction

   always_comb begin
      unique case (sel)
         2'd0:    y = a;
         2'd1:    y = b;
         2'd2:    y = c;
         default: y = d;
      endcase
   end

   assign y_valid     = ~rst & (state == GRANT) & req[sel];
   assign accept      = y_valid & out_ready;
   assign ack         = accept ? onehot(sel) : 4'b0000;
   assign next_ptr    = sel + 2'd1;
   assign release_now = ~req[sel] | (accept & ((hold_cnt + 4'd1) == HOLD_LIMIT));

   always_comb begin
      state_nxt    = state;
      sel_nxt      = sel;
      gnt_nxt      = gnt;
      ptr_nxt      = ptr;
      hold_cnt_nxt = hold_cnt;
      unique case (state)
         IDLE: begin
            if (req != 4'b0000) begin
               sel_nxt      = winner(req, ptr);
               gnt_nxt      = onehot(winner(req, ptr));
               hold_cnt_nxt = 4'd0;
               state_nxt    = GRANT;
            end
         end
         GRANT: begin
            if (release_now) begin
               ptr_nxt = next_ptr;
               // Regrant on the release edge so contention never idles the path.
               if (req != 4'b0000) begin
                  sel_nxt      = winner(req, next_ptr);
                  gnt_nxt      = onehot(winner(req, next_ptr));
                  hold_cnt_nxt = 4'd0;
               end else begin
                  gnt_nxt      = 4'b0000;
                  hold_cnt_nxt = 4'd0;
                  state_nxt    = IDLE;
               end
            end else if (accept) begin
               hold_cnt_nxt = hold_cnt + 4'd1;
            end
         end
         default: begin
            state_nxt = IDLE;
            gnt_nxt   = 4'b0000;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         sel      <= 2'd0;
         gnt      <= 4'b0000;
         ptr      <= 2'd0;
         hold_cnt <= 4'd0;
      end else begin
         state    <= state_nxt;
         sel      <= sel_nxt;
         gnt      <= gnt_nxt;
         ptr      <= ptr_nxt;
         hold_cnt <= hold_cnt_nxt;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_mux4_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mux4_rr_arbiter
// Brief    : Randomized self-checking bench against a behavioural arbiter model.
// Revision : 1.0
// ============================================================================
module tb_mux4_rr_arbiter;

   localparam int MAX_HOLD = 4;
   localparam int NCYC     = 3000;

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] req;
   logic [3:0] a, b, c, d;
   logic       out_ready;
   logic [1:0] sel;
   logic [3:0] gnt;
   logic [3:0] y;
   logic       y_valid;
   logic [3:0] ack;

   int n_checks = 0;
   int n_pass   = 0;

   // Model state: who holds the path, where the round-robin scan starts next,
   // and how many transfers the current holder has had accepted.
   bit m_busy;
   int m_sel, m_ptr, m_cnt;

   mux4_rr_arbiter #(.MAX_HOLD(MAX_HOLD)) dut (
      .clk(clk), .rst(rst), .req(req),
      .a(a), .b(b), .c(c), .d(d),
      .out_ready(out_ready),
      .sel(sel), .gnt(gnt), .y(y), .y_valid(y_valid), .ack(ack)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input int obs, input int exp);
      n_checks++;
      if (obs == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
   endtask

   function automatic int pick(input logic [3:0] r, input int p);
      for (int off = 0; off < 4; off++)
         if (r[(p + off) % 4]) return (p + off) % 4;
      return -1;
   endfunction

   function automatic int data_of(input int s);
      case (s)
         0: return int'(a);
         1: return int'(b);
         2: return int'(c);
         default: return int'(d);
      endcase
   endfunction

   task automatic compare_outputs();
      int exp_valid;
      exp_valid = (!rst && m_busy && req[m_sel]) ? 1 : 0;
      check("sel", int'(sel), m_sel);
      check("gnt", int'(gnt), m_busy ? (1 << m_sel) : 0);
      check("y", int'(y), data_of(m_sel));
      check("y_valid", int'(y_valid), exp_valid);
      check("ack", int'(ack), (exp_valid && out_ready) ? (1 << m_sel) : 0);
   endtask

   // Advances the model by one clock edge using the inputs held during the cycle.
   task automatic model_step();
      bit took;
      if (rst) begin
         m_busy = 0; m_sel = 0; m_ptr = 0; m_cnt = 0;
      end else if (!m_busy) begin
         if (req != 0) begin
            m_sel = pick(req, m_ptr); m_busy = 1; m_cnt = 0;
         end
      end else begin
         took = req[m_sel] && out_ready;
         if (took) m_cnt++;
         if (!req[m_sel] || (took && m_cnt == MAX_HOLD)) begin
            m_ptr = (m_sel + 1) % 4;
            m_cnt = 0;
            if (req != 0) m_sel = pick(req, m_ptr);
            else m_busy = 0;
         end
      end
   endtask

   initial begin
      int mode;
      rst = 1'b1; req = 4'b1111; out_ready = 1'b1;
      a = 4'h1; b = 4'h2; c = 4'h3; d = 4'h4;
      @(posedge clk);
      model_step();
      #1;
      // Second reset cycle with every requester active: nothing may be granted.
      #2 compare_outputs();
      @(posedge clk); model_step(); #1;
      mode = 0;
      for (int k = 0; k < NCYC; k++) begin
         if (k % 60 == 0) mode = int'($urandom_range(0, 3));
         rst = ($urandom_range(0, 99) == 0);
         a = 4'($urandom); b = 4'($urandom); c = 4'($urandom); d = 4'($urandom);
         case (mode)
            0: begin
               req = 4'b1111;
               out_ready = ($urandom_range(0, 3) != 0);
            end
            1: begin
               if ($urandom_range(0, 7) == 0) req = 4'($urandom);
               out_ready = ($urandom_range(0, 3) != 0);
            end
            2: begin
               req = 4'($urandom);
               out_ready = 1'($urandom);
            end
            default: begin
               // Single steady requester exercises back-to-back self-regrant.
               if (k % 60 == 0) req = 4'b0001 << $urandom_range(0, 3);
               out_ready = ($urandom_range(0, 4) != 0);
            end
         endcase
         #2 compare_outputs();
         @(posedge clk);
         model_step();
         #1;
      end
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/mux4_rr_arbiter.md
Name: mux4_rr_arbiter

Overview:
- Round-robin arbiter and sequencer sharing one 4-bit, 4-way data path between four requesters (a, b, c, d).
- Drives the 2-bit path select, multiplexes the winner's data, and runs a valid/ready transfer to a single downstream consumer.
- Bounds each grant to MAX_HOLD transfers for fairness.
- Sits between the four 4-bit sources and the shared sink, replacing a static select.

Parameters:
- MAX_HOLD, 4, max consecutive accepted transfers per grant (1..15); hold counter is 4 bits.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- req  input  4  per-requester request; req[0]=a … req[3]=d
- a  input  4  requester 0 data
- b  input  4  requester 1 data
- c  input  4  requester 2 data
- d  input  4  requester 3 data
- out_ready  input  1  downstream accepts y this cycle
- sel  output  2  registered path select (0=a, 1=b, 2=c, 3=d)
- gnt  output  4  registered one-hot grant; all zero when idle
- y  output  4  combinational path output: a/b/c/d per sel
- y_valid  output  1  gnt nonzero AND req[sel] high AND rst low
- ack  output  4  one-hot; ack[sel] = y_valid & out_ready (transfer accepted)

Behaviour:
- Interface: one clock (clk); reset rst is synchronous, active-high. All state changes on rising clk edge.
- Reset values:
  - state=IDLE, gnt=0000, sel=00, ptr=00, hold_cnt=0.
  - y_valid=0 and ack=0000 while rst is high, regardless of state; y follows sel, so y=a.
- States: IDLE (no grant), GRANT (gnt[sel]=1).
- Winner function W(p): first set bit of req scanning p, p+1, p+2, p+3 (mod 4).
- IDLE:
  - If req != 0: at the next edge, sel<=W(ptr), gnt<=onehot(W(ptr)), hold_cnt<=0, state<=GRANT.
  - Latency: req high in cycle N -> gnt/y_valid in cycle N+1.
- GRANT:
  - y_valid=1 when req[sel]=1.
  - Each cycle with ack nonzero increments hold_cnt.
  - out_ready low: hold_cnt frozen, grant kept, y_valid stays 1, ack=0.
- Release at the edge ending cycle N, when either:
  - req[sel]=0 in cycle N, or
  - an accepted transfer in cycle N makes hold_cnt reach MAX_HOLD.
- On release:
  - ptr<=sel+1 (wraps 3->0).
  - If req != 0 in cycle N, regrant on that same edge to W(sel+1), hold_cnt<=0 (no idle bubble). Otherwise gnt<=0000, state<=IDLE; sel keeps its value.
  - If the current requester is the only one still requesting after MAX_HOLD, it is regranted immediately with hold_cnt cleared.
- Requests arriving for non-granted requesters never preempt the current grant.
- sel and gnt change only at grant or release edges, never mid-grant.
- Reset mid-operation: rst high in any cycle forces y_valid/ack to 0 that cycle. The next edge applies the reset values; in-flight burst count is discarded.
- No registered data path: y is purely combinational from sel and the a/b/c/d inputs.

Test Plan:
- Reset: rst=1 for 2 cycles with req=1111, out_ready=1 -> gnt=0000, sel=0, y_valid=0, ack=0000 throughout; first grant to a one cycle after rst falls.
- Single requester: req=0100, c=4'hA, out_ready=1 -> cycle+1: gnt=0100, sel=2, y=A, y_valid=1, ack=0100. After 4 acks, regranted to c with hold_cnt=0; no cycle with y_valid=0.
- Full contention: req=1111 held, out_ready=1, MAX_HOLD=4 -> grant sequence a,b,c,d,a…, each exactly 4 consecutive ack cycles, no idle cycles between grants.
- Backpressure: b granted, out_ready=0 for 3 cycles mid-burst -> y_valid=1, ack=0000, hold_cnt unchanged, sel=1. After out_ready returns, exactly MAX_HOLD total acks to b.
- Early drop with wrap: a granted, req=1011 then req[0] falls after 2 acks (req=1010) -> next cycle gnt=0010 (b beats d since ptr=1). After b's burst, d wins, then ptr wraps to 0.
- Reset mid-burst: c granted, 2 acks done, rst pulsed 1 cycle -> ack=0 in rst cycle; next cycle gnt=0000, ptr=0; with req=0100 still high, c regranted one cycle later with a full MAX_HOLD budget.
